// File: rtl/pipeline_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, owner and
// read/write encodings, access-size constant, the data word returned on an
// aborted access, and a helper that sizes saturating counters.
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  // Memory rw convention: 1 = read, 0 = write.
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [1:0]  ACCESS_WORD  = 2'b00;
  localparam logic [31:0] TIMEOUT_FILL = 32'hDEADBEEF;

  // Bits needed to hold the values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/arb_select.sv
// Owner selection policy for mem_arbiter.
// D-port has fixed priority; once STARVE_LIMIT consecutive D grants have been
// made while the I-port was waiting, the next grant goes to the I-port.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-high reset
//   i_req, d_req  eligible requests (already masked by the arbiter)
//   grant         a grant is being made this cycle to `owner`
//   owner         combinational pick: OWNER_D or OWNER_I
module arb_select
  import pipeline_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  input  logic grant,
  output logic owner
);

  localparam int CW = cnt_width(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          starved;

  always_comb begin
    starved = (starve_cnt_q == LIMIT) && i_req;
    owner   = (d_req && !starved) ? OWNER_D : OWNER_I;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (grant) begin
      // Only a D grant that leaves the I-port waiting counts towards starvation.
      if (owner == OWNER_I || !i_req) begin
        starve_cnt_d = '0;
      end else if (starve_cnt_q != LIMIT) begin
        starve_cnt_d = starve_cnt_q + CW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) starve_cnt_q <= '0;
    else       starve_cnt_q <= starve_cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory between the fetch stage (I-port, read only) and the MEM
// stage (D-port, read/write). Each access is sequenced IDLE -> ISSUE -> WAIT;
// completion pulses the owner's ready for one cycle with registered rdata.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   i_req/i_address/i_access_size -> i_rdata, i_ready, i_stall
//   d_req/d_rw/d_address/d_data_in/d_access_size -> d_rdata, d_ready, d_stall
//   m_address/m_data_in/m_access_size/m_rw/m_enable -> memory; m_busy/m_data_out <- memory
//   err                   sticky timeout flag, cleared only by reset
module mem_arbiter
  import pipeline_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_address,
  input  logic [1:0]  i_access_size,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  output logic        i_stall,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_address,
  input  logic [31:0] d_data_in,
  input  logic [1:0]  d_access_size,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_stall,
  output logic [31:0] m_address,
  output logic [31:0] m_data_in,
  output logic [1:0]  m_access_size,
  output logic        m_rw,
  output logic        m_enable,
  input  logic        m_busy,
  input  logic [31:0] m_data_out,
  output logic        err
);

  localparam int TW = cnt_width(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  arb_state_e  state_q, state_d;
  logic        owner_q, owner_d;
  logic [31:0] m_address_q, m_address_d;
  logic [31:0] m_data_in_q, m_data_in_d;
  logic [1:0]  m_access_size_q, m_access_size_d;
  logic        m_rw_q, m_rw_d;
  logic        m_enable_q, m_enable_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic        i_ready_q, i_ready_d;
  logic        d_ready_q, d_ready_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        err_q, err_d;

  logic i_req_eff, d_req_eff, any_req, grant, pick;

  // A port's held req is not a new request while its own access is in flight
  // or during its ready pulse; it becomes eligible again the cycle after.
  always_comb begin
    i_req_eff = i_req && !i_ready_q && !(state_q != IDLE && owner_q == OWNER_I);
    d_req_eff = d_req && !d_ready_q && !(state_q != IDLE && owner_q == OWNER_D);
    any_req   = i_req_eff || d_req_eff;
  end

  arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb_select (
    .clock (clock),
    .reset (reset),
    .i_req (i_req_eff),
    .d_req (d_req_eff),
    .grant (grant),
    .owner (pick)
  );

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    m_address_d     = m_address_q;
    m_data_in_d     = m_data_in_q;
    m_access_size_d = m_access_size_q;
    m_rw_d          = m_rw_q;
    m_enable_d      = 1'b0;
    tmo_d           = tmo_q;
    i_ready_d       = 1'b0;
    d_ready_d       = 1'b0;
    i_rdata_d       = i_rdata_q;
    d_rdata_d       = d_rdata_q;
    err_d           = err_q;
    grant           = 1'b0;

    case (state_q)
      IDLE: grant = any_req;
      ISSUE: begin
        state_d = WAIT;
        tmo_d   = '0;
      end
      WAIT: begin
        if (!m_busy) begin
          if (owner_q == OWNER_I) begin
            i_ready_d = 1'b1;
            i_rdata_d = m_data_out;
          end else begin
            d_ready_d = 1'b1;
            if (m_rw_q == RW_READ) d_rdata_d = m_data_out;
          end
          state_d = IDLE;
          grant   = any_req;
        end else if (tmo_q == TMO_LAST) begin
          // Abort: the fill word is returned to the owner even for a write,
          // so the pipeline sees an unmistakable marker alongside err.
          err_d   = 1'b1;
          state_d = IDLE;
          if (owner_q == OWNER_I) begin
            i_ready_d = 1'b1;
            i_rdata_d = TIMEOUT_FILL;
          end else begin
            d_ready_d = 1'b1;
            d_rdata_d = TIMEOUT_FILL;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      state_d    = ISSUE;
      m_enable_d = 1'b1;
      owner_d    = pick;
      if (pick == OWNER_D) begin
        m_address_d     = d_address;
        m_data_in_d     = d_data_in;
        m_access_size_d = d_access_size;
        m_rw_d          = d_rw;
      end else begin
        m_address_d     = i_address;
        m_data_in_d     = '0;
        m_access_size_d = i_access_size;
        m_rw_d          = RW_READ;
      end
    end
  end

  // NOTE: the command and rdata registers are reset along with the control
  // state because they drive module outputs that must read 0 out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      owner_q         <= OWNER_I;
      m_address_q     <= '0;
      m_data_in_q     <= '0;
      m_access_size_q <= '0;
      m_rw_q          <= 1'b0;
      m_enable_q      <= 1'b0;
      tmo_q           <= '0;
      i_ready_q       <= 1'b0;
      d_ready_q       <= 1'b0;
      i_rdata_q       <= '0;
      d_rdata_q       <= '0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      m_address_q     <= m_address_d;
      m_data_in_q     <= m_data_in_d;
      m_access_size_q <= m_access_size_d;
      m_rw_q          <= m_rw_d;
      m_enable_q      <= m_enable_d;
      tmo_q           <= tmo_d;
      i_ready_q       <= i_ready_d;
      d_ready_q       <= d_ready_d;
      i_rdata_q       <= i_rdata_d;
      d_rdata_q       <= d_rdata_d;
      err_q           <= err_d;
    end
  end

  assign i_rdata       = i_rdata_q;
  assign i_ready       = i_ready_q;
  assign i_stall       = i_req & ~i_ready_q;
  assign d_rdata       = d_rdata_q;
  assign d_ready       = d_ready_q;
  assign d_stall       = d_req & ~d_ready_q;
  assign m_address     = m_address_q;
  assign m_data_in     = m_data_in_q;
  assign m_access_size = m_access_size_q;
  assign m_rw          = m_rw_q;
  assign m_enable      = m_enable_q;
  assign err           = err_q;

endmodule
